// File: rtl/latch_puf_array_ctrl_if.sv
// Host-side challenge/response handshake for the latch PUF sequencer.
// stable_mask exists only when PUF_STABILITY_EN is defined.
interface latch_puf_array_ctrl_if #(
  parameter int N_CELLS = 16
);
  logic               start;
  logic [N_CELLS-1:0] challenge;
  logic               busy;
  logic [N_CELLS-1:0] resp;
  logic               resp_valid;
  logic               resp_ack;
`ifdef PUF_STABILITY_EN
  logic [N_CELLS-1:0] stable_mask;
`endif

  modport master (
    output start,
    output challenge,
    output resp_ack,
    input  busy,
    input  resp,
`ifdef PUF_STABILITY_EN
    input  stable_mask,
`endif
    input  resp_valid
  );

  modport slave (
    input  start,
    input  challenge,
    input  resp_ack,
    output busy,
    output resp,
`ifdef PUF_STABILITY_EN
    output stable_mask,
`endif
    output resp_valid
  );
endinterface

// File: rtl/latch_puf_array_ctrl.sv
// Excite/release sequencer and majority voter for an SR-latch PUF bank.
// Optional PUF_STABILITY_EN adds a per-cell unanimous-vote mask.
module latch_puf_array_ctrl #(
  parameter int N_CELLS       = 16,
  parameter int N_EVALS       = 7,
  parameter int EXCITE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  latch_puf_array_ctrl_if.slave bus,
  output logic [N_CELLS-1:0] cell_s_n,
  output logic [N_CELLS-1:0] cell_r_n,
  input  logic [N_CELLS-1:0] cell_q
);
  localparam int TW = $clog2(N_EVALS + 1);
  localparam int CMAX = (EXCITE_CYCLES > SETTLE_CYCLES) ?
                        EXCITE_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, EXCITE, SETTLE, SAMPLE, VOTE, DONE
  } state_t;

  state_t state, state_n;

  logic [N_CELLS-1:0] mask;
  logic [N_CELLS-1:0] q_meta;
  logic [N_CELLS-1:0] q_sync;
  logic [N_CELLS-1:0] resp_q;
  logic [CW-1:0]      ph_cnt;
  logic [TW-1:0]      ev_cnt;
  logic [TW-1:0]      tally [N_CELLS];
  logic               excite;
  logic               busy;
  logic               resp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    busy       = 1'b0;
    resp_valid = 1'b0;
    excite     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_n = EXCITE;
      end
      EXCITE: begin
        busy   = 1'b1;
        excite = 1'b1;
        if (ph_cnt == CW'(EXCITE_CYCLES - 1)) state_n = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (ph_cnt == CW'(SETTLE_CYCLES - 1)) state_n = SAMPLE;
      end
      SAMPLE: begin
        busy    = 1'b1;
        state_n = (ev_cnt == TW'(N_EVALS - 1)) ? VOTE : EXCITE;
      end
      VOTE: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (bus.resp_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask   <= '0;
      q_meta <= '0;
      q_sync <= '0;
      resp_q <= '0;
      ph_cnt <= '0;
      ev_cnt <= '0;
      for (int i = 0; i < N_CELLS; i++) tally[i] <= '0;
    end else begin
      q_meta <= cell_q;
      q_sync <= q_meta;
      // Phase counter restarts on every state change.
      if (state_n != state) ph_cnt <= '0;
      else if (state == EXCITE || state == SETTLE)
        ph_cnt <= ph_cnt + 1'b1;
      if (state == IDLE && bus.start) begin
        mask   <= bus.challenge;
        ev_cnt <= '0;
        for (int i = 0; i < N_CELLS; i++) tally[i] <= '0;
      end
      if (state == SAMPLE) begin
        ev_cnt <= ev_cnt + 1'b1;
        for (int i = 0; i < N_CELLS; i++)
          tally[i] <= tally[i] + TW'(q_sync[i] & mask[i]);
      end
      if (state == VOTE) begin
        for (int i = 0; i < N_CELLS; i++)
          resp_q[i] <= mask[i] & (tally[i] > TW'(N_EVALS / 2));
      end
    end
  end

`ifdef PUF_STABILITY_EN
  logic [N_CELLS-1:0] stable_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '0;
    end else if (state == VOTE) begin
      for (int i = 0; i < N_CELLS; i++)
        stable_q[i] <= mask[i] &
          ((tally[i] == '0) || (tally[i] == TW'(N_EVALS)));
    end
  end

  assign bus.stable_mask = stable_q;
`endif

  // Reset forces IDLE and a zero mask, so cells release asynchronously.
  assign cell_s_n       = excite ? ~mask : '1;
  assign cell_r_n       = excite ? ~mask : '1;
  assign bus.busy       = busy;
  assign bus.resp_valid = resp_valid;
  assign bus.resp       = resp_q;
endmodule

// File: tb/tb_latch_puf_array_ctrl.sv
// Directed bench for latch_puf_array_ctrl (8 cells, 5 evals, 2/4 cycles).
// Stability checks are compiled in when PUF_STABILITY_EN is defined.
module tb_latch_puf_array_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cell_s_n;
  logic [7:0] cell_r_n;
  logic [7:0] cell_q;
  int         checks = 0;
  int         errors = 0;
  int         lat;

  latch_puf_array_ctrl_if #(.N_CELLS(8)) bus ();

  latch_puf_array_ctrl #(
    .N_CELLS(8),
    .N_EVALS(5),
    .EXCITE_CYCLES(2),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cell_s_n(cell_s_n),
    .cell_r_n(cell_r_n),
    .cell_q(cell_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // mode 0 plain, 1 stray start/ack, 2 reset in SAMPLE, 3 drive checks
  task automatic run(input logic [7:0]  chal,
                     input logic [39:0] qv,
                     input int          mode,
                     input bit          launched,
                     output int         l);
    int bcnt;
    bcnt = 0;
    l    = -1;
    if (!launched) begin
      cell_q        = qv[7:0];
      bus.challenge = chal;
      bus.start     = 1'b1;
      cyc();
      bus.start     = 1'b0;
    end
    for (int n = 1; n <= 100; n++) begin
      cyc();
      if (n % 7 == 0 && n / 7 < 5) cell_q = qv[8*(n/7) +: 8];
      if (mode == 1) begin
        if (n == 7)  bus.resp_ack = 1'b1;
        if (n == 8)  bus.resp_ack = 1'b0;
        if (n == 10) bus.start    = 1'b1;
        if (n == 11) bus.start    = 1'b0;
      end
      if (mode == 3 && n == 1) begin
        check("exc_s_n", 32'(cell_s_n), 32'hF0);
        check("exc_r_n", 32'(cell_r_n), 32'hF0);
      end
      if (mode == 3 && n == 3) begin
        check("set_s_n", 32'(cell_s_n), 32'hFF);
        check("set_r_n", 32'(cell_r_n), 32'hFF);
      end
      if (mode == 2 && n == 20) begin
        #2 rst = 1'b1;
        #1;
        check("rst_busy",  32'(bus.busy), 32'h0);
        check("rst_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_resp",  32'(bus.resp), 32'h0);
        check("rst_s_n",   32'(cell_s_n), 32'hFF);
        check("rst_r_n",   32'(cell_r_n), 32'hFF);
`ifdef PUF_STABILITY_EN
        check("rst_stab",  32'(bus.stable_mask), 32'h0);
`endif
        rst = 1'b0;
        return;
      end
      if (bus.resp_valid) begin
        l = n;
        break;
      end
      if (bus.busy) bcnt++;
    end
    check("busy_cycles", 32'(bcnt), 32'd35);
    check("busy_fall", 32'(bus.busy), 32'h0);
  endtask

  task automatic ack();
    bus.resp_ack = 1'b1;
    cyc();
    bus.resp_ack = 1'b0;
    check("ack_valid", 32'(bus.resp_valid), 32'h0);
    check("ack_busy",  32'(bus.busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.challenge = '0;
    bus.resp_ack  = 1'b0;
    cell_q        = '0;
    cyc();
    cyc();
    check("reset_busy",  32'(bus.busy), 32'h0);
    check("reset_valid", 32'(bus.resp_valid), 32'h0);
    check("reset_resp",  32'(bus.resp), 32'h0);
    check("reset_s_n",   32'(cell_s_n), 32'hFF);
    check("reset_r_n",   32'(cell_r_n), 32'hFF);
    rst = 1'b0;
    cyc();

    // Latency and handshake
    run(8'hFF, {5{8'hA5}}, 0, 1'b0, lat);
    check("t1_lat",  32'(lat), 32'd36);
    check("t1_resp", 32'(bus.resp), 32'hA5);
`ifdef PUF_STABILITY_EN
    check("t1_stab", 32'(bus.stable_mask), 32'hFF);
`endif
    ack();
    check("t1_hold", 32'(bus.resp), 32'hA5);

    // Masking and drive
    run(8'h0F, {5{8'hFF}}, 3, 1'b0, lat);
    check("t2_lat",  32'(lat), 32'd36);
    check("t2_resp", 32'(bus.resp), 32'h0F);
    ack();

    // Majority: bit0 1,1,0,0,1 ; bit1 0,1,0,0,0 ; bits 7:2 = 101100
    run(8'hFF, {8'hB1, 8'hB0, 8'hB0, 8'hB3, 8'hB1}, 0, 1'b0, lat);
    check("t3_lat",  32'(lat), 32'd36);
    check("t3_resp", 32'(bus.resp), 32'hB1);
`ifdef PUF_STABILITY_EN
    check("t3_stab", 32'(bus.stable_mask), 32'hFC);
`endif
    ack();

    // Stray start in SETTLE and ack in EXCITE are ignored
    run(8'hFF, {5{8'hA5}}, 1, 1'b0, lat);
    check("t4_lat",  32'(lat), 32'd36);
    check("t4_resp", 32'(bus.resp), 32'hA5);
    ack();

    // Reset mid-run, then a fresh full run
    run(8'hFF, {5{8'h3C}}, 2, 1'b0, lat);
    cyc();
    check("t5_idle", 32'(bus.busy), 32'h0);
    run(8'hFF, {5{8'h3C}}, 0, 1'b0, lat);
    check("t5_lat",  32'(lat), 32'd36);
    check("t5_resp", 32'(bus.resp), 32'h3C);

    // Back-to-back: start held with ack in DONE
    cell_q        = 8'h5A;
    bus.challenge = 8'hFF;
    bus.start     = 1'b1;
    bus.resp_ack  = 1'b1;
    cyc();
    bus.resp_ack  = 1'b0;
    check("t6_valid", 32'(bus.resp_valid), 32'h0);
    check("t6_nobusy", 32'(bus.busy), 32'h0);
    cyc();
    bus.start = 1'b0;
    check("t6_busy", 32'(bus.busy), 32'h1);
    run(8'hFF, {5{8'h5A}}, 0, 1'b1, lat);
    check("t6_lat",  32'(lat), 32'd36);
    check("t6_resp", 32'(bus.resp), 32'h5A);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/latch_puf_array_ctrl.md
Name: latch_puf_array_ctrl

Overview:
- Sequencer for a bank of N cross-coupled NAND SR-latch PUF cells.
- Per evaluation: drives all selected cells through excite (S=R=0, forces Q=Qn=1), then release (S=R=1) so each cell resolves by mismatch.
- Samples resolved Q values and repeats N_EVALS times. Majority-votes each cell into a stable response word.
- Sits between the challenge/response host interface and the latch bank. The latch bank is external, so the cell outputs arrive on an input port.

Parameters:
- N_CELLS, 16: number of latch cells and response width.
- N_EVALS, 7: evaluations per challenge; must be odd and ≥1.
- EXCITE_CYCLES, 2: cycles cells are held with S=R=0; ≥1.
- SETTLE_CYCLES, 8: cycles after release before sampling; ≥3, which covers the 2-flop synchroniser.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request evaluation; accepted only in IDLE.
- challenge  in  N_CELLS  cell enable mask; captured when start is accepted.
- busy  out  1  high from the cycle after acceptance until resp_valid.
- cell_s_n  out  N_CELLS  S input per cell (active-low set).
- cell_r_n  out  N_CELLS  R input per cell (active-low reset).
- cell_q  in  N_CELLS  Q outputs from the latch bank; asynchronous.
- resp  out  N_CELLS  voted response.
- resp_valid  out  1  response available.
- resp_ack  in  1  host consumes response.
- stable_mask  out  N_CELLS  present only with PUF_STABILITY_EN.

Behaviour:
- Reset state (asynchronous): state=IDLE, busy=0, resp=0, resp_valid=0, all counters and tallies 0, cell_s_n=cell_r_n=all ones (release), synchroniser=0, captured mask=0.
- cell_q passes through a 2-flop synchroniser that is clocked every cycle.
- Tally per cell: width clog2(N_EVALS+1).
- IDLE:
  - On start=1: capture challenge, clear tallies and eval counter, go to EXCITE.
  - start is ignored in every state except IDLE.
- EXCITE, for EXCITE_CYCLES cycles:
  - Selected cells get s_n=r_n=0.
  - Unselected cells stay at 1/1 throughout the whole operation.
- SETTLE, for SETTLE_CYCLES cycles: all cells get s_n=r_n=1.
- SAMPLE, 1 cycle:
  - tally[i] += synchronised q[i] & mask[i].
  - Eval counter +1.
  - If eval counter == N_EVALS-1 before increment, go to VOTE; otherwise go to EXCITE.
- VOTE, 1 cycle:
  - resp[i] = mask[i] & (tally[i] > N_EVALS/2).
  - Go to DONE.
- DONE:
  - resp_valid=1 and resp is held stable.
  - On resp_ack=1: resp_valid=0 next cycle, go to IDLE; resp keeps its last value.
  - resp_ack outside DONE is ignored.
- Latency: start accepted at edge 0 → resp_valid=1 after N_EVALS·(EXCITE_CYCLES+SETTLE_CYCLES+1)+1 edges.
- busy:
  - 1 in EXCITE, SETTLE, SAMPLE and VOTE; 0 in IDLE and DONE.
  - The cycle busy falls is the cycle resp_valid rises.
- Simultaneous start and resp_ack in DONE: the ack is taken, start is dropped; the host re-issues start in IDLE.
- Reset mid-operation: immediate return to the reset state, with cells released (1/1) asynchronously. No partial response is exposed.
- Challenge of all zeros: runs the full sequence and yields resp=0.
- Tally cannot overflow, because its width covers N_EVALS.

Optional Feature:
- PUF_STABILITY_EN defined:
  - stable_mask port exists. Set in VOTE to stable[i] = mask[i] & (tally[i]==0 | tally[i]==N_EVALS).
  - Cleared on reset, held with resp.
- PUF_STABILITY_EN undefined: no port, no extra logic; behaviour is otherwise identical.

Test Plan:
Bench parameters: N_CELLS=8, N_EVALS=5, EXCITE_CYCLES=2, SETTLE_CYCLES=4.
- Latency and handshake: challenge=8'hFF, cell_q constant 8'hA5, start pulse → busy for 35 cycles; resp_valid at edge 36; resp=8'hA5. resp_ack → resp_valid=0 next cycle, state IDLE.
- Masking and drive: challenge=8'h0F, cell_q=8'hFF → cell_s_n/cell_r_n=8'hF0 during EXCITE and 8'hFF during SETTLE; resp=8'h0F.
- Majority vote: bit0 sampled 1,1,0,0,1 and bit1 sampled 0,1,0,0,0 across the 5 SAMPLE cycles → resp[0]=1, resp[1]=0. With PUF_STABILITY_EN, stable_mask[1:0]=2'b00 and all other constant bits are 1.
- Ignored inputs: start asserted during SETTLE of eval 2 and resp_ack asserted in EXCITE → no restart, same latency, resp unchanged.
- Reset mid-run: rst in SAMPLE of eval 3 → outputs immediately at reset values, cells 8'hFF/8'hFF. A new start then gives full latency 36.
- Back-to-back: start held high through DONE together with resp_ack → returns to IDLE. Next start is accepted only on the following cycle; second resp is correct.
